// File: rtl/rom_seq_checker.sv
// Successor-ROM sequence checker: locks onto a 3-bit counting stream, flags mismatches.
// Optional mismatch counter and clear are enabled by defining SEQ_CHK_ERRCNT_EN.
module rom_seq_checker #(
    parameter int LOCK_LEN    = 4,
    parameter int UNLOCK_MISS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] state_in,
    input  logic       valid_in,
    input  logic       clear,
    output logic       locked,
    output logic       error,
    output logic [7:0] err_count,
    output logic [2:0] expected
);

    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_LOCKING  = 2'd1,
        S_LOCKED   = 2'd2
    } state_t;

    localparam logic [2:0] ROM [8] = '{
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0
    };

    localparam logic [3:0] LOCK_TGT   = 4'(LOCK_LEN);
    localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_MISS);

    state_t     state;
    logic [2:0] prev;
    logic [3:0] run;
    logic [3:0] miss;
    logic       hit;
    logic       miss_hit;
    logic [3:0] run_nx;
    logic [3:0] miss_nx;

    // prediction is a pure ROM lookup of the last sampled value
    assign expected = ROM[prev];
    assign hit      = (state_in == expected);
    assign miss_hit = valid_in && (state == S_LOCKED) && !hit;
    assign run_nx   = run + 4'd1;
    assign miss_nx  = miss + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_UNLOCKED;
            prev   <= 3'd0;
            run    <= 4'd0;
            miss   <= 4'd0;
            locked <= 1'b0;
            error  <= 1'b0;
        end else begin
            error <= 1'b0;
            if (valid_in) begin
                prev <= state_in;
                unique case (state)
                    S_UNLOCKED: begin
                        run   <= 4'd0;
                        state <= S_LOCKING;
                    end
                    S_LOCKING: begin
                        if (!hit) begin
                            run <= 4'd0;
                        end else if (run_nx == LOCK_TGT) begin
                            run    <= 4'd0;
                            state  <= S_LOCKED;
                            locked <= 1'b1;
                        end else begin
                            run <= run_nx;
                        end
                    end
                    S_LOCKED: begin
                        if (hit) begin
                            miss <= 4'd0;
                        end else begin
                            error <= 1'b1;
                            if (miss_nx == UNLOCK_TGT) begin
                                miss   <= 4'd0;
                                state  <= S_UNLOCKED;
                                locked <= 1'b0;
                            end else begin
                                miss <= miss_nx;
                            end
                        end
                    end
                    default: begin
                        state  <= S_UNLOCKED;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SEQ_CHK_ERRCNT_EN
    // clear wins over a same-edge mismatch; the error pulse is unaffected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (clear) begin
            err_count <= 8'd0;
        end else if (miss_hit && (err_count != 8'hff)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = clear ^ miss_hit;
    assign err_count  = 8'd0;
`endif

endmodule

// File: tb/tb_rom_seq_checker.sv
// Directed bench for rom_seq_checker with hand-computed expectations.
// Counter expectations follow SEQ_CHK_ERRCNT_EN when it is defined for the build.
module tb_rom_seq_checker;

    logic       clk;
    logic       rst_n;
    logic [2:0] state_in;
    logic       valid_in;
    logic       clear;
    logic       locked;
    logic       error;
    logic [7:0] err_count;
    logic [2:0] expected;

`ifdef SEQ_CHK_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int n_chk;
    int n_pass;

    rom_seq_checker #(
        .LOCK_LEN(4),
        .UNLOCK_MISS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .state_in(state_in),
        .valid_in(valid_in),
        .clear(clear),
        .locked(locked),
        .error(error),
        .err_count(err_count),
        .expected(expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    endtask

    function automatic int ec(input int v);
        return CNT_EN ? v : 0;
    endfunction

    task automatic step(input logic v, input logic [2:0] s, input logic c);
        @(negedge clk);
        valid_in = v;
        state_in = s;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] p;

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        state_in = 3'd0;
        clear    = 1'b0;
        #12;
        chk("rst_locked", int'(locked), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_cnt", int'(err_count), 0);
        chk("rst_exp", int'(expected), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // acquire lock on 0,1,2,3,4
        step(1'b1, 3'd0, 1'b0);
        chk("acq0_locked", int'(locked), 0);
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd3, 1'b0);
        chk("acq3_locked", int'(locked), 0);
        chk("acq3_err", int'(error), 0);
        step(1'b1, 3'd4, 1'b0);
        chk("acq4_locked", int'(locked), 1);
        chk("acq4_err", int'(error), 0);
        chk("acq4_exp", int'(expected), 5);

        // idle gap must not disturb anything
        step(1'b0, 3'd7, 1'b0);
        step(1'b0, 3'd2, 1'b0);
        step(1'b0, 3'd7, 1'b0);
        chk("gap_locked", int'(locked), 1);
        chk("gap_exp", int'(expected), 5);

        // wrap 7 -> 0
        step(1'b1, 3'd5, 1'b0);
        step(1'b1, 3'd6, 1'b0);
        step(1'b1, 3'd7, 1'b0);
        step(1'b1, 3'd0, 1'b0);
        step(1'b1, 3'd1, 1'b0);
        chk("wrap_locked", int'(locked), 1);
        chk("wrap_err", int'(error), 0);
        chk("wrap_exp", int'(expected), 2);

        // single miss recovered by a match
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd3, 1'b0);
        step(1'b1, 3'd5, 1'b0);
        chk("m1_err", int'(error), 1);
        chk("m1_cnt", int'(err_count), ec(1));
        chk("m1_locked", int'(locked), 1);
        chk("m1_exp", int'(expected), 6);
        step(1'b1, 3'd6, 1'b0);
        chk("m1r_err", int'(error), 0);
        chk("m1r_locked", int'(locked), 1);

        // two consecutive misses unlock
        step(1'b1, 3'd7, 1'b0);
        step(1'b1, 3'd0, 1'b0);
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd3, 1'b0);
        step(1'b1, 3'd5, 1'b0);
        chk("m2a_err", int'(error), 1);
        chk("m2a_cnt", int'(err_count), ec(2));
        chk("m2a_locked", int'(locked), 1);
        step(1'b1, 3'd2, 1'b0);
        chk("m2b_err", int'(error), 1);
        chk("m2b_cnt", int'(err_count), ec(3));
        chk("m2b_locked", int'(locked), 0);
        chk("m2b_exp", int'(expected), 3);
        step(1'b0, 3'd0, 1'b0);
        chk("m2c_err", int'(error), 0);

        // relock, with a mismatch while LOCKING restarting the run
        step(1'b1, 3'd0, 1'b0);
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd6, 1'b0);
        chk("lk_miss_err", int'(error), 0);
        chk("lk_miss_cnt", int'(err_count), ec(3));
        chk("lk_miss_locked", int'(locked), 0);
        step(1'b1, 3'd7, 1'b0);
        step(1'b1, 3'd0, 1'b0);
        step(1'b1, 3'd1, 1'b0);
        chk("lk3_locked", int'(locked), 0);
        step(1'b1, 3'd2, 1'b0);
        chk("lk4_locked", int'(locked), 1);

        // clear on an idle cycle
        step(1'b0, 3'd0, 1'b1);
        chk("clr_cnt", int'(err_count), 0);
        chk("clr_locked", int'(locked), 1);
        chk("clr_exp", int'(expected), 3);

        // 255 isolated misses, each followed by a match
        p = 3'd2;
        for (int i = 0; i < 255; i++) begin
            p = 3'(p + 3'd2);
            step(1'b1, p, 1'b0);
            p = 3'(p + 3'd1);
            step(1'b1, p, 1'b0);
        end
        chk("sat_cnt", int'(err_count), ec(255));
        chk("sat_locked", int'(locked), 1);
        p = 3'(p + 3'd2);
        step(1'b1, p, 1'b0);
        chk("sat2_err", int'(error), 1);
        chk("sat2_cnt", int'(err_count), ec(255));
        p = 3'(p + 3'd1);
        step(1'b1, p, 1'b0);
        chk("sat3_err", int'(error), 0);
        p = 3'(p + 3'd2);
        step(1'b1, p, 1'b1);
        chk("clrmiss_err", int'(error), 1);
        chk("clrmiss_cnt", int'(err_count), 0);
        chk("clrmiss_locked", int'(locked), 1);

        // asynchronous reset during the error pulse
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_locked", int'(locked), 0);
        chk("arst_err", int'(error), 0);
        chk("arst_cnt", int'(err_count), 0);
        chk("arst_exp", int'(expected), 1);
        @(negedge clk);
        rst_n    = 1'b1;
        valid_in = 1'b0;
        clear    = 1'b0;
        step(1'b1, 3'd5, 1'b0);
        chk("post_locked", int'(locked), 0);
        chk("post_err", int'(error), 0);
        chk("post_exp", int'(expected), 6);
        step(1'b1, 3'd6, 1'b0);
        step(1'b1, 3'd7, 1'b0);
        step(1'b1, 3'd0, 1'b0);
        step(1'b1, 3'd1, 1'b0);
        chk("post_relock", int'(locked), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
